mem_line_arbiter: RTL and testbench

- Shares the single 128-bit line-wide backing memory port between the instruction-cache refill path and the data-cache path.
- The icache line request (F_mem_req/F_mem_addr) and the dcache line read/write request each see a private req/valid handshake.
- The arbiter serialises them onto one memory transaction at a time with round-robin fairness.
- Sits between the caches and the instruction/data memory model.

---
 rtl/mem_line_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_line_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the icache
// refill path and the dcache path; one memory transaction in flight at a time.
module mem_line_arbiter #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I_req,
    input  logic [ADDR_W-1:0] I_addr,
    output logic [LINE_W-1:0] I_rdata,
    output logic              I_valid,
    input  logic              D_req,
    input  logic              D_we,
    input  logic [ADDR_W-1:0] D_addr,
    input  logic [LINE_W-1:0] D_wdata,
    output logic [LINE_W-1:0] D_rdata,
    output logic              D_valid,
    output logic              M_req,
    output logic              M_we,
    output logic [ADDR_W-1:0] M_addr,
    output logic [LINE_W-1:0] M_wdata,
    input  logic [LINE_W-1:0] M_rdata,
    input  logic              M_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_e            state_q,   state_d;
    logic              owner_q,   owner_d;
    logic              last_q,    last_d;
    logic              m_req_q,   m_req_d;
    logic              m_we_q,    m_we_d;
    logic [ADDR_W-1:0] m_addr_q,  m_addr_d;
    logic [LINE_W-1:0] m_wdata_q, m_wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_valid_q, i_valid_d;
    logic              d_valid_q, d_valid_d;
    logic              pick_s;

    // State and output registers; last grant resets to D so I wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_I;
            last_q    <= OWN_D;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= {ADDR_W{1'b0}};
            m_wdata_q <= {LINE_W{1'b0}};
            i_rdata_q <= {LINE_W{1'b0}};
            d_rdata_q <= {LINE_W{1'b0}};
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_valid_q <= i_valid_d;
            d_valid_q <= d_valid_d;
        end
    end

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        if (I_req && D_req) begin
            pick_s = ~last_q;
        end else begin
            pick_s = D_req;
        end
    end

    // Next-state and next-output logic; valid pulses default low every cycle.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_valid_d = 1'b0;
        d_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (I_req || D_req) begin
                    owner_d = pick_s;
                    last_d  = pick_s;
                    m_req_d = 1'b1;
                    if (pick_s == OWN_D) begin
                        m_addr_d  = D_addr;
                        m_we_d    = D_we;
                        m_wdata_d = D_wdata;
                    end else begin
                        m_addr_d  = I_addr;
                        m_we_d    = 1'b0;
                        m_wdata_d = m_wdata_q;
                    end
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (M_ready) begin
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    if (owner_q == OWN_I) begin
                        i_rdata_d = M_rdata;
                        i_valid_d = 1'b1;
                    end else begin
                        // A write acknowledgement leaves the read-data register alone.
                        if (!m_we_q) begin
                            d_rdata_d = M_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                        d_valid_d = 1'b1;
                    end
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign I_rdata = i_rdata_q;
    assign I_valid = i_valid_q;
    assign D_rdata = d_rdata_q;
    assign D_valid = d_valid_q;
    assign M_req   = m_req_q;
    assign M_we    = m_we_q;
    assign M_addr  = m_addr_q;
    assign M_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Bench for mem_line_arbiter: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mem_line_arbiter;
    localparam int LINE_W = 128;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              I_req, D_req, D_we, M_ready;
    logic [ADDR_W-1:0] I_addr, D_addr;
    logic [LINE_W-1:0] D_wdata, M_rdata;
    logic [LINE_W-1:0] I_rdata, D_rdata, M_wdata;
    logic              I_valid, D_valid, M_req, M_we;
    logic [ADDR_W-1:0] M_addr;

    int compared   = 0;
    int mismatched = 0;
    bit auto_mem   = 1'b0;
    bit auto_req   = 1'b0;

    // Reference model: one transaction in flight, a response cycle after it.
    bit              mdl_busy, mdl_resp, mdl_owner, mdl_last, mdl_we;
    bit [ADDR_W-1:0] mdl_addr;
    bit [LINE_W-1:0] mdl_wdata, mdl_irdata, mdl_drdata;
    bit              grants[$];

    mem_line_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .I_req(I_req), .I_addr(I_addr), .I_rdata(I_rdata), .I_valid(I_valid),
        .D_req(D_req), .D_we(D_we), .D_addr(D_addr), .D_wdata(D_wdata),
        .D_rdata(D_rdata), .D_valid(D_valid),
        .M_req(M_req), .M_we(M_we), .M_addr(M_addr), .M_wdata(M_wdata),
        .M_rdata(M_rdata), .M_ready(M_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mdl_busy   = 1'b0;
        mdl_resp   = 1'b0;
        mdl_owner  = 1'b0;
        mdl_last   = 1'b1;
        mdl_we     = 1'b0;
        mdl_addr   = '0;
        mdl_wdata  = '0;
        mdl_irdata = '0;
        mdl_drdata = '0;
    endfunction

    // Advances the model by one clock edge using the inputs present at that edge.
    function automatic void model_update();
        if (!rst_n) begin
            model_reset();
        end else if (mdl_resp) begin
            mdl_resp = 1'b0;
        end else if (mdl_busy) begin
            if (M_ready) begin
                mdl_busy = 1'b0;
                mdl_resp = 1'b1;
                if (!mdl_owner) mdl_irdata = M_rdata;
                else if (!mdl_we) mdl_drdata = M_rdata;
            end
        end else if (I_req || D_req) begin
            mdl_owner = (I_req && D_req) ? !mdl_last : D_req;
            mdl_last  = mdl_owner;
            mdl_busy  = 1'b1;
            mdl_addr  = mdl_owner ? D_addr : I_addr;
            mdl_we    = mdl_owner ? D_we : 1'b0;
            if (mdl_owner) mdl_wdata = D_wdata;
            grants.push_back(mdl_owner);
        end
    endfunction

    task automatic compare();
        chk("M_req",   M_req,   mdl_busy);
        chk("M_we",    M_we,    mdl_busy && mdl_we);
        if (mdl_busy) chk("M_addr", M_addr, mdl_addr);
        if (mdl_busy && mdl_we) chk("M_wdata", M_wdata, mdl_wdata);
        chk("I_valid", I_valid, mdl_resp && !mdl_owner);
        chk("D_valid", D_valid, mdl_resp && mdl_owner);
        chk("I_rdata", I_rdata, mdl_irdata);
        chk("D_rdata", D_rdata, mdl_drdata);
    endtask

    task automatic drive_random();
        if (auto_mem) begin
            if (M_ready) begin
                M_ready = 1'b0;
            end else if (M_req && $urandom_range(0, 2) == 0) begin
                M_ready = 1'b1;
                M_rdata = rand_line();
            end else if (!M_req && $urandom_range(0, 9) == 0) begin
                M_ready = 1'b1;
                M_rdata = rand_line();
            end
        end
        if (auto_req) begin
            if (I_valid && $urandom_range(0, 3) != 0) I_req = 1'b0;
            else if (!I_req && $urandom_range(0, 3) == 0) begin
                I_req  = 1'b1;
                I_addr = ADDR_W'($urandom_range(0, 7));
            end else if ($urandom_range(0, 19) == 0) I_req = 1'b0;
            if ($urandom_range(0, 7) == 0) I_addr = ADDR_W'($urandom_range(0, 7));
            if (D_valid && $urandom_range(0, 3) != 0) D_req = 1'b0;
            else if (!D_req && $urandom_range(0, 3) == 0) begin
                D_req   = 1'b1;
                D_we    = 1'($urandom_range(0, 1));
                D_addr  = ADDR_W'($urandom_range(0, 7));
                D_wdata = rand_line();
            end else if ($urandom_range(0, 19) == 0) D_req = 1'b0;
            if ($urandom_range(0, 7) == 0) D_wdata = rand_line();
        end
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
        drive_random();
    endtask

    initial begin
        rst_n = 1'b1; I_req = 1'b0; D_req = 1'b0; D_we = 1'b0; M_ready = 1'b0;
        I_addr = '0; D_addr = '0; D_wdata = '0; M_rdata = '0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare();
        chk("rst_M_req", M_req, 1'b0);
        chk("rst_M_addr", M_addr, 3'd0);
        chk("rst_I_rdata", I_rdata, 128'd0);
        repeat (2) step();
        rst_n = 1'b1;

        // icache read of line 5, memory answers on the second wait cycle
        I_req = 1'b1; I_addr = 3'd5;
        step();
        chk("t1_M_req", M_req, 1'b1);
        chk("t1_M_addr", M_addr, 3'd5);
        chk("t1_M_we", M_we, 1'b0);
        step();
        M_ready = 1'b1; M_rdata = {32{4'hA}};
        step();
        chk("t1_I_valid", I_valid, 1'b1);
        chk("t1_I_rdata", I_rdata, {32{4'hA}});
        chk("t1_D_valid", D_valid, 1'b0);
        M_ready = 1'b0; I_req = 1'b0;
        step();
        chk("t1_I_valid_off", I_valid, 1'b0);

        // dcache write of line 3
        D_req = 1'b1; D_we = 1'b1; D_addr = 3'd3; D_wdata = 128'h1234;
        step();
        chk("t2_M_we", M_we, 1'b1);
        chk("t2_M_addr", M_addr, 3'd3);
        chk("t2_M_wdata", M_wdata, 128'h1234);
        step();
        M_ready = 1'b1; M_rdata = 128'hDEAD_BEEF;
        step();
        chk("t2_D_valid", D_valid, 1'b1);
        chk("t2_D_rdata", D_rdata, 128'd0);
        chk("t2_I_valid", I_valid, 1'b0);
        M_ready = 1'b0; D_req = 1'b0; D_we = 1'b0;
        step();
        chk("t2_D_valid_off", D_valid, 1'b0);

        // both requesters held high: grants must alternate
        grants.delete();
        I_req = 1'b1; I_addr = 3'd1; D_req = 1'b1; D_addr = 3'd6;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("t3_M_addr", M_addr, (n % 2 == 0) ? 3'd1 : 3'd6);
            M_ready = 1'b1; M_rdata = rand_line();
            step();
            M_ready = 1'b0;
            step();
        end
        chk("t3_grant_count", grants.size(), 4);
        if (grants.size() == 4) begin
            for (int n = 0; n < 4; n++) chk("t3_grant_order", grants[n], (n % 2 == 0) ? 1'b0 : 1'b1);
        end
        I_req = 1'b0; D_req = 1'b0;
        step();

        // requester inputs change during the wait
        I_req = 1'b1; I_addr = 3'd2;
        step();
        I_addr = 3'd6; I_req = 1'b0;
        step();
        chk("t4_M_addr_held", M_addr, 3'd2);
        chk("t4_M_req_held", M_req, 1'b1);
        M_ready = 1'b1; M_rdata = 128'h55;
        step();
        chk("t4_I_valid", I_valid, 1'b1);
        chk("t4_I_rdata", I_rdata, 128'h55);
        M_ready = 1'b0;
        step();

        // reset in the middle of a wait abandons the transaction
        I_req = 1'b1; I_addr = 3'd4;
        step();
        chk("t5_M_req_pre", M_req, 1'b1);
        I_req = 1'b0; rst_n = 1'b0;
        model_reset();
        #1;
        compare();
        chk("t5_M_req", M_req, 1'b0);
        chk("t5_M_addr", M_addr, 3'd0);
        chk("t5_I_rdata", I_rdata, 128'd0);
        step();
        rst_n = 1'b1; M_ready = 1'b1; M_rdata = rand_line();
        step();
        chk("t5_I_valid", I_valid, 1'b0);
        chk("t5_D_valid", D_valid, 1'b0);
        M_ready = 1'b0;
        step();
        chk("t5_I_valid_late", I_valid, 1'b0);

        // stray M_ready with nothing outstanding
        M_ready = 1'b1; M_rdata = rand_line();
        step();
        M_ready = 1'b0;
        step();
        chk("t6_M_req", M_req, 1'b0);
        chk("t6_I_valid", I_valid, 1'b0);
        chk("t6_D_valid", D_valid, 1'b0);

        auto_mem = 1'b1; auto_req = 1'b1;
        repeat (4000) step();
        auto_req = 1'b0; I_req = 1'b0; D_req = 1'b0;
        repeat (40) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
